// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out: timing counters, frame-RAM fetch and a delay-matched 3-3-2 colour path.
// Defining VGA_SCANOUT_TESTPAT_EN adds input itestpat, which swaps the colour ID for 64-pixel vertical bars.
module vga_scanout #(
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int RAM_LATENCY    = 2,
  parameter int V_ACTIVE       = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [VGA_ADDR_WIDTH-1:0] oaddr,
  output logic                      orden,
  input  logic [COLOR_ID_WIDTH-1:0] idata,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic                      itestpat,
`endif
  output logic [7:0]                vga_r,
  output logic [7:0]                vga_g,
  output logic [7:0]                vga_b,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic                      vga_blank_n,
  output logic                      vga_sync_n,
  output logic                      ovblank
);

  // Pipeline depth from counters to pins: address register, RAM latency, colour register.
  localparam int D = RAM_LATENCY + 2;

  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0]                hcnt;
  logic [9:0]                vcnt;
  logic                      visible;
  logic                      hs_raw;
  logic                      vs_raw;
  logic [VGA_ADDR_WIDTH-1:0] lin_addr;
  logic [D-1:0]              vis_pipe;
  logic [D-1:0]              hs_pipe;
  logic [D-1:0]              vs_pipe;
  logic [7:0]                color_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  always_comb begin
    visible = (hcnt < H_ACTIVE) && (vcnt < V_ACT);
    hs_raw  = (hcnt >= H_SYNC_START) && (hcnt <= H_SYNC_END);
    vs_raw  = (vcnt >= V_SYNC_START) && (vcnt <= V_SYNC_END);
  end

  // vcnt*640 + hcnt built from shifts so no multiplier is inferred.
  assign lin_addr = (VGA_ADDR_WIDTH'(vcnt) << 9) + (VGA_ADDR_WIDTH'(vcnt) << 7)
                  + VGA_ADDR_WIDTH'(hcnt);

  // No handshake: the RAM port is read every visible clock and answers a fixed RAM_LATENCY later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      orden   <= 1'b0;
      oaddr   <= '0;
      ovblank <= 1'b0;
    end else begin
      orden   <= visible;
      oaddr   <= visible ? lin_addr : '0;
      ovblank <= (vcnt >= V_ACT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vis_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      vis_pipe <= {vis_pipe[D-2:0], visible};
      hs_pipe  <= {hs_pipe[D-2:0], hs_raw};
      vs_pipe  <= {vs_pipe[D-2:0], vs_raw};
    end
  end

`ifdef VGA_SCANOUT_TESTPAT_EN
  // Bar index travels with the pixel so it meets idata at the colour register.
  logic [3:0] bar_pipe [D-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D - 1; i++) bar_pipe[i] <= '0;
    end else begin
      bar_pipe[0] <= hcnt[9:6];
      for (int i = 1; i < D - 1; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  always_comb begin
    color_id = 8'(idata);
    if (itestpat) color_id = {bar_pipe[D-2], bar_pipe[D-2]};
  end
`else
  always_comb begin
    color_id = 8'(idata);
  end
`endif

  // vis_pipe[D-2] is the flag of the pixel whose RAM data is on idata right now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (vis_pipe[D-2]) begin
      vga_r <= {color_id[7:5], color_id[7:5], color_id[7:6]};
      vga_g <= {color_id[4:2], color_id[4:2], color_id[4:3]};
      vga_b <= {4{color_id[1:0]}};
    end else begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end
  end

  assign vga_blank_n = vis_pipe[D-1];
  assign vga_hs      = ~hs_pipe[D-1];
  assign vga_vs      = ~vs_pipe[D-1];
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: a full-size instance for line-level behaviour and a
// short-frame instance (11 lines) for frame timing, vertical blank and mid-frame reset.
module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ram_mode = 0;
  int   errors = 0;
  int   checks = 0;

  always #20 clk = ~clk;

  logic [18:0] oaddr_a, oaddr_b;
  logic        orden_a, orden_b;
  logic [7:0]  idata_a, idata_b, ram_s1_a, ram_s1_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, blank_n_a, sync_n_a, ovblank_a;
  logic        hs_b, vs_b, blank_n_b, sync_n_b, ovblank_b;
`ifdef VGA_SCANOUT_TESTPAT_EN
  logic        itestpat = 1'b0;
`endif

  vga_scanout dut_a (
    .clk(clk), .rst(rst), .oaddr(oaddr_a), .orden(orden_a), .idata(idata_a),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .itestpat(itestpat),
`endif
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
    .vga_blank_n(blank_n_a), .vga_sync_n(sync_n_a), .ovblank(ovblank_a)
  );

  vga_scanout #(.V_ACTIVE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_b (
    .clk(clk), .rst(rst), .oaddr(oaddr_b), .orden(orden_b), .idata(idata_b),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .itestpat(1'b0),
`endif
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vga_blank_n(blank_n_b), .vga_sync_n(sync_n_b), .ovblank(ovblank_b)
  );

  function automatic logic [7:0] ram_word(input logic [18:0] addr, input logic en);
    case (ram_mode)
      0:       return addr[7:0];
      1:       return (en && addr == 19'd0) ? 8'hE0 : 8'h00;
      default: return 8'hFF;
    endcase
  endfunction

  // Frame RAM model: two-clock read latency.
  always @(posedge clk) begin
    ram_s1_a <= ram_word(oaddr_a, orden_a);
    idata_a  <= ram_s1_a;
    ram_s1_b <= ram_word(oaddr_b, orden_b);
    idata_b  <= ram_s1_b;
  end

  function automatic logic [23:0] exp_rgb(input logic [7:0] id);
    return {id[7:5], id[7:5], id[7:6], id[4:2], id[4:2], id[4:3], {4{id[1:0]}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (oaddr_a !== 19'd0) begin errors++; $display("FAIL reset_oaddr: got %0d expected 0", oaddr_a); end
    checks++; if (orden_a !== 1'b0) begin errors++; $display("FAIL reset_orden: got %b expected 0", orden_a); end
    checks++; if ({r_a, g_a, b_a} !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", {r_a, g_a, b_a}); end
    checks++; if ({hs_a, vs_a} !== 2'b11) begin errors++; $display("FAIL reset_syncs: got %b expected 11", {hs_a, vs_a}); end
    checks++; if (blank_n_a !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b expected 0", blank_n_a); end
    checks++; if (ovblank_a !== 1'b0) begin errors++; $display("FAIL reset_ovblank: got %b expected 0", ovblank_a); end
    checks++; if (sync_n_a !== 1'b0) begin errors++; $display("FAIL sync_n_const: got %b expected 0", sync_n_a); end
    checks++; if ({orden_b, hs_b, vs_b, blank_n_b} !== 4'b0110) begin errors++; $display("FAIL reset_small: got %b expected 0110", {orden_b, hs_b, vs_b, blank_n_b}); end
  endtask

  // RAM echoes oaddr[7:0]; checks fetch address/enable and the delayed colour per clock.
  task automatic test_address_sequence();
    int p, h, v, q, qh, qv, e_addr;
    logic e_vis, q_vis;
    logic [23:0] e_rgb;
    ram_mode = 0;
    do_reset();
    for (int n = 1; n <= 1700; n++) begin
      tick();
      p = n - 1; h = p % 800; v = p / 800;
      e_vis = (h < 640);
      e_addr = e_vis ? v * 640 + h : 0;
      checks++; if (orden_a !== e_vis) begin errors++; $display("FAIL addr_orden px%0d: got %b expected %b", p, orden_a, e_vis); end
      checks++; if (oaddr_a !== 19'(e_addr)) begin errors++; $display("FAIL addr_value px%0d: got %0d expected %0d", p, oaddr_a, e_addr); end
      if (n >= 4) begin
        q = n - 4; qh = q % 800; qv = q / 800;
        q_vis = (qh < 640);
        e_rgb = q_vis ? exp_rgb(8'(qv * 640 + qh)) : 24'h0;
        checks++; if (blank_n_a !== q_vis) begin errors++; $display("FAIL addr_blank px%0d: got %b expected %b", q, blank_n_a, q_vis); end
        checks++; if ({r_a, g_a, b_a} !== e_rgb) begin errors++; $display("FAIL addr_rgb px%0d: got %h expected %h", q, {r_a, g_a, b_a}, e_rgb); end
      end
    end
  endtask

  task automatic test_alignment();
    int first_blank = -1, blank_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
    logic [23:0] rgb_first = 24'h0, rgb_next = 24'h0;
    ram_mode = 1;
    do_reset();
    for (int n = 1; n <= 810; n++) begin
      tick();
      if (blank_n_a && first_blank < 0) begin first_blank = n; rgb_first = {r_a, g_a, b_a}; end
      if (first_blank > 0 && n == first_blank + 1) rgb_next = {r_a, g_a, b_a};
      if (n >= 4 && n <= 803) begin
        if (blank_n_a) blank_cnt++;
        if (!hs_a) begin hs_cnt++; if (hs_first < 0) hs_first = n; hs_last = n; end
      end
    end
    checks++; if (first_blank != 4) begin errors++; $display("FAIL align_first_blank: got edge %0d expected 4", first_blank); end
    checks++; if (rgb_first !== 24'hFF0000) begin errors++; $display("FAIL align_rgb_first: got %h expected ff0000", rgb_first); end
    checks++; if (rgb_next[23:16] !== 8'h00) begin errors++; $display("FAIL align_r_next: got %h expected 00", rgb_next[23:16]); end
    checks++; if (blank_cnt != 640) begin errors++; $display("FAIL align_blank_len: got %0d expected 640", blank_cnt); end
    checks++; if (hs_cnt != 96) begin errors++; $display("FAIL hs_len: got %0d expected 96", hs_cnt); end
    checks++; if (hs_first != 660 || hs_last != 755) begin errors++; $display("FAIL hs_pos: got %0d..%0d expected 660..755", hs_first, hs_last); end
  endtask

  task automatic test_blank_forcing();
    int q;
    logic q_vis;
    ram_mode = 2;
    do_reset();
    for (int n = 1; n <= 1700; n++) begin
      tick();
      q = n - 4;
      q_vis = (n >= 4) && ((q % 800) < 640);
      checks++;
      if ({blank_n_a, r_a, g_a, b_a} !== {q_vis, q_vis ? 24'hFFFFFF : 24'h0}) begin
        errors++;
        $display("FAIL blank_force edge%0d: got %b/%h expected %b/%h", n, blank_n_a, {r_a, g_a, b_a}, q_vis, q_vis ? 24'hFFFFFF : 24'h0);
      end
    end
  endtask

  // Short frame: 4 visible + 2 front + 2 sync + 3 back = 11 lines, 8800 clocks.
  task automatic test_frame_timing();
    int vs_cnt = 0, hs_cnt = 0, bl_cnt = 0, ov_cnt = 0, en_cnt = 0, ov_first = -1, vs_n = 0;
    int vs_start[2] = '{-1, -1};
    int max_addr = 0;
    logic vs_prev = 1'b1;
    ram_mode = 0;
    do_reset();
    for (int n = 1; n <= 17604; n++) begin
      tick();
      if (n <= 17600) begin
        if (ovblank_b) begin ov_cnt++; if (ov_first < 0) ov_first = n; end
        if (orden_b) en_cnt++;
        if (int'(oaddr_b) > max_addr) max_addr = int'(oaddr_b);
      end
      if (n == 3040) begin
        checks++; if (oaddr_b !== 19'd2559) begin errors++; $display("FAIL last_visible_addr: got %0d expected 2559", oaddr_b); end
      end
      if (n >= 4 && n <= 17603) begin
        if (!vs_b) vs_cnt++;
        if (!hs_b) hs_cnt++;
        if (blank_n_b) bl_cnt++;
      end
      if (!vs_b && vs_prev && vs_n < 2) begin vs_start[vs_n] = n; vs_n++; end
      vs_prev = vs_b;
    end
    checks++; if (vs_cnt != 3200) begin errors++; $display("FAIL vs_len: got %0d expected 3200", vs_cnt); end
    checks++; if (hs_cnt != 2112) begin errors++; $display("FAIL hs_total: got %0d expected 2112", hs_cnt); end
    checks++; if (bl_cnt != 5120) begin errors++; $display("FAIL blank_total: got %0d expected 5120", bl_cnt); end
    checks++; if (vs_start[0] != 4804) begin errors++; $display("FAIL vs_start0: got %0d expected 4804", vs_start[0]); end
    checks++; if (vs_start[1] != 13604) begin errors++; $display("FAIL vs_start1: got %0d expected 13604", vs_start[1]); end
    checks++; if (ov_first != 3201) begin errors++; $display("FAIL ovblank_first: got %0d expected 3201", ov_first); end
    checks++; if (ov_cnt != 11200) begin errors++; $display("FAIL ovblank_cnt: got %0d expected 11200", ov_cnt); end
    checks++; if (en_cnt != 5120) begin errors++; $display("FAIL orden_cnt: got %0d expected 5120", en_cnt); end
    checks++; if (max_addr != 2559) begin errors++; $display("FAIL max_addr: got %0d expected 2559", max_addr); end
  endtask

  task automatic test_reset_mid_frame();
    ram_mode = 2;
    do_reset();
    repeat (1900) tick();
    checks++; if ({orden_b, blank_n_b, r_b} !== {2'b11, 8'hFF}) begin errors++; $display("FAIL mid_pre: got %b%b/%h expected 11/ff", orden_b, blank_n_b, r_b); end
    rst = 1'b1;
    #1;
    checks++; if ({orden_b, oaddr_b} !== 20'h0) begin errors++; $display("FAIL mid_async_fetch: got %b/%0d expected 0/0", orden_b, oaddr_b); end
    checks++; if ({hs_b, vs_b, blank_n_b, ovblank_b} !== 4'b1100) begin errors++; $display("FAIL mid_async_ctrl: got %b expected 1100", {hs_b, vs_b, blank_n_b, ovblank_b}); end
    checks++; if ({r_b, g_b, b_b} !== 24'h0) begin errors++; $display("FAIL mid_async_rgb: got %h expected 000000", {r_b, g_b, b_b}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++; if ({orden_b, oaddr_b} !== {1'b1, 19'(n - 1)}) begin errors++; $display("FAIL mid_restart_addr edge%0d: got %b/%0d expected 1/%0d", n, orden_b, oaddr_b, n - 1); end
      checks++; if (blank_n_b !== (n >= 4)) begin errors++; $display("FAIL mid_restart_blank edge%0d: got %b expected %b", n, blank_n_b, n >= 4); end
    end
  endtask

`ifdef VGA_SCANOUT_TESTPAT_EN
  task automatic test_testpat();
    ram_mode = 2;
    itestpat = 1'b1;
    do_reset();
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (n == 4) begin
        checks++; if ({blank_n_a, r_a, g_a, b_a} !== {1'b1, 24'h0}) begin errors++; $display("FAIL testpat_bar0: got %b/%h expected 1/000000", blank_n_a, {r_a, g_a, b_a}); end
      end
      if (n == 65) begin
        checks++; if (orden_a !== 1'b1) begin errors++; $display("FAIL testpat_orden: got %b expected 1", orden_a); end
      end
      if (n == 68) begin
        checks++; if ({r_a, g_a, b_a} !== 24'h009255) begin errors++; $display("FAIL testpat_bar1: got %h expected 009255", {r_a, g_a, b_a}); end
      end
    end
    itestpat = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_address_sequence();
    test_alignment();
    test_blank_forcing();
    test_frame_timing();
    test_reset_mid_frame();
`ifdef VGA_SCANOUT_TESTPAT_EN
    test_testpat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
